// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-serial program loader and a 1-cycle fetch port.
// Define IMEM_BOOT_CLEAR_EN to zero the whole memory in a BOOT phase after reset.
module instr_mem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic [31:0] instruction,
  output logic        fetch_valid,
  output logic        fetch_err,
  input  logic        load_en,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  output logic        load_full,
  output logic        busy
);

  typedef enum logic [1:0] {BOOT, READY, LOAD} state_e;

`ifdef IMEM_BOOT_CLEAR_EN
  localparam state_e RESET_STATE = BOOT;
  logic [AW-1:0] clr_q, clr_d;
`else
  localparam state_e RESET_STATE = READY;
`endif

  state_e        state_q, state_d;
  logic [AW:0]   ptr_q, ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   asm_q, asm_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  logic [AW-1:0] fetch_idx;
  logic          fetch_bad;

  assign fetch_idx = fetch_addr[AW+1:2];
  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:AW+2] != '0);

  // Pointer MSB set means all DEPTH words were written this session.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    instr_d   = '0;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr_q[AW-1:0];
    mem_wdata = {asm_q[23:0], load_byte};
`ifdef IMEM_BOOT_CLEAR_EN
    clr_d     = clr_q;
`endif
    case (state_q)
      BOOT: begin
`ifdef IMEM_BOOT_CLEAR_EN
        mem_we    = 1'b1;
        mem_waddr = clr_q;
        mem_wdata = '0;
        clr_d     = clr_q + 1'b1;
        if (clr_q == AW'(DEPTH - 1)) state_d = READY;
`else
        state_d = READY;
`endif
      end
      READY: begin
        if (load_en) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          asm_d   = '0;
        end else if (fetch_req) begin
          valid_d = 1'b1;
          err_d   = fetch_bad;
          instr_d = fetch_bad ? 32'h0 : mem[fetch_idx];
        end
      end
      LOAD: begin
        if (!load_en) begin
          state_d = READY;
        end else if (load_valid && !ptr_q[AW]) begin
          asm_d = {asm_q[23:0], load_byte};
          if (cnt_q == 2'd3) begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_STATE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_BOOT_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef IMEM_BOOT_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  // Storage is deliberately not reset so programs survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign instruction = instr_q;
  assign fetch_valid = valid_q;
  assign fetch_err   = err_q;
  assign load_full   = ptr_q[AW];
  assign busy        = (state_q != READY);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader (default build, DEPTH=64).
module tb_instr_mem_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] instruction;
  logic        fetch_valid;
  logic        fetch_err;
  logic        load_en;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_full;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(.DEPTH(64)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .instruction(instruction), .fetch_valid(fetch_valid), .fetch_err(fetch_err),
    .load_en(load_en), .load_valid(load_valid), .load_byte(load_byte),
    .load_full(load_full), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    load_valid = 1'b1;
    load_byte  = b;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic fetchCheck(input string tag, input logic [31:0] addr,
                            input logic [31:0] expInstr, input logic expErr);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_req  = 1'b0;
    checkOutput({tag, "_valid"}, 32'(fetch_valid), 32'd1);
    checkOutput({tag, "_instr"}, instruction, expInstr);
    checkOutput({tag, "_err"}, 32'(fetch_err), 32'(expErr));
  endtask

  initial begin
    reset = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    load_en = 1'b0; load_valid = 1'b0; load_byte = '0;
    tick();
    checkOutput("rst_instr", instruction, 32'h0);
    checkOutput("rst_valid", 32'(fetch_valid), 32'd0);
    checkOutput("rst_err", 32'(fetch_err), 32'd0);
    checkOutput("rst_full", 32'(load_full), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("ready_busy", 32'(busy), 32'd0);

    // Fill all 64 words with byte i = i; two extra bytes must be ignored.
    load_en = 1'b1;
    tick();
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("load_full_entry", 32'(load_full), 32'd0);
    for (int i = 0; i < 258; i++) begin
      applyStimulus(8'(i));
      if (i == 254) checkOutput("full_before", 32'(load_full), 32'd0);
      if (i == 255) checkOutput("full_after", 32'(load_full), 32'd1);
    end
    checkOutput("full_hold", 32'(load_full), 32'd1);
    load_en = 1'b0;
    tick();
    checkOutput("exit_busy", 32'(busy), 32'd0);
    fetchCheck("fill_w0", 32'h0, 32'h00010203, 1'b0);
    fetchCheck("fill_w63", 32'hFC, 32'hFCFDFEFF, 1'b0);
    fetchCheck("fill_w32", 32'h80, 32'h80818283, 1'b0);

    // Two-word program, then back-to-back fetches.
    load_en = 1'b1;
    tick();
    checkOutput("full_cleared", 32'(load_full), 32'd0);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    fetch_req = 1'b0;
    checkOutput("fetch_in_load", 32'(fetch_valid), 32'd0);
    applyStimulus(8'h20); applyStimulus(8'h08); applyStimulus(8'h00); applyStimulus(8'h20);
    applyStimulus(8'h20); applyStimulus(8'h09); applyStimulus(8'h00); applyStimulus(8'h37);
    load_en = 1'b0;
    tick();
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    checkOutput("b2b0_valid", 32'(fetch_valid), 32'd1);
    checkOutput("b2b0_instr", instruction, 32'h20080020);
    checkOutput("b2b0_err", 32'(fetch_err), 32'd0);
    fetch_addr = 32'h4;
    tick();
    fetch_req = 1'b0;
    checkOutput("b2b1_valid", 32'(fetch_valid), 32'd1);
    checkOutput("b2b1_instr", instruction, 32'h20090037);
    checkOutput("b2b1_err", 32'(fetch_err), 32'd0);
    tick();
    checkOutput("idle_valid", 32'(fetch_valid), 32'd0);
    checkOutput("idle_instr", instruction, 32'h0);
    checkOutput("idle_err", 32'(fetch_err), 32'd0);

    fetchCheck("misalign", 32'h6, 32'h0, 1'b1);
    fetchCheck("range", 32'h100, 32'h0, 1'b1);
    fetchCheck("last_ok", 32'hF8, 32'hF8F9FAFB, 1'b0);

    // load_en rising with fetch_req: load wins, then a 6-byte partial load.
    load_en = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    fetch_req = 1'b0;
    checkOutput("race_valid", 32'(fetch_valid), 32'd0);
    checkOutput("race_busy", 32'(busy), 32'd1);
    applyStimulus(8'hAA); applyStimulus(8'hBB); applyStimulus(8'hCC); applyStimulus(8'hDD);
    applyStimulus(8'h11); applyStimulus(8'h22);
    load_en = 1'b0;
    tick();
    fetchCheck("part_w0", 32'h0, 32'hAABBCCDD, 1'b0);
    fetchCheck("part_w1", 32'h4, 32'h20090037, 1'b0);
    fetchCheck("part_w2", 32'h8, 32'h08090A0B, 1'b0);

    // load_valid outside LOAD has no effect.
    for (int i = 0; i < 4; i++) applyStimulus(8'h5A);
    fetchCheck("ready_bytes", 32'h0, 32'hAABBCCDD, 1'b0);

    // Reset while a fetch result is showing clears outputs immediately.
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    fetch_req = 1'b0;
    checkOutput("pre_rst_valid", 32'(fetch_valid), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("async_valid", 32'(fetch_valid), 32'd0);
    checkOutput("async_instr", instruction, 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // Reset mid-LOAD aborts the load; memory is retained.
    load_en = 1'b1;
    tick();
    applyStimulus(8'h55); applyStimulus(8'h66);
    checkOutput("midload_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_full", 32'(load_full), 32'd0);
    checkOutput("abort_err", 32'(fetch_err), 32'd0);
    load_en = 1'b0; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    checkOutput("rst_fetch_drop", 32'(fetch_valid), 32'd0);
    reset = 1'b1;
    tick();
    fetchCheck("retain_w0", 32'h0, 32'hAABBCCDD, 1'b0);
    fetchCheck("retain_w1", 32'h4, 32'h20090037, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the number of 32-bit instruction words (power of two, 4..1024).
REQ-002 Parameter AW, default $clog2(DEPTH), SHALL set the internal word-index width.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 fetch_req  in  1  SHALL carry a one-cycle fetch request.
REQ-006 fetch_addr  in  32  SHALL carry the byte address of the fetch.
REQ-007 instruction  out  32  SHALL carry the fetched word, registered.
REQ-008 fetch_valid  out  1  SHALL be high for one cycle when instruction is valid.
REQ-009 fetch_err  out  1  SHALL be high with fetch_valid on a misaligned or out-of-range fetch.
REQ-010 load_en  in  1  SHALL be the loader mode request, level-sensitive.
REQ-011 load_valid  in  1  SHALL qualify load_byte.
REQ-012 load_byte  in  8  SHALL carry one program byte, most significant byte of each word first.
REQ-013 load_full  out  1  SHALL flag that DEPTH words were written in the current load session.
REQ-014 busy  out  1  SHALL be high in every state except READY.

Function
REQ-015 FSM states SHALL be BOOT, READY and LOAD.
- BOOT -> READY once the clear counter reaches DEPTH-1 (REQ-030).
- READY -> LOAD when load_en=1.
- LOAD -> READY when load_en=0.
REQ-016 In READY, fetch_req=1 SHALL produce fetch_valid=1 and instruction on the next cycle (latency 1), one result per request, back-to-back requests every cycle supported.
REQ-017 A word index SHALL be fetch_addr[AW+1:2]; a fetch SHALL be in range only if fetch_addr>>2 < DEPTH.
REQ-018 A fetch with fetch_addr[1:0]!=0 or out of range SHALL return instruction=0 (NOP) with fetch_err=1 and fetch_valid=1.
REQ-019 When fetch_valid=0, instruction SHALL be 0 and fetch_err SHALL be 0.
REQ-020 fetch_req outside READY SHALL be dropped: no fetch_valid, no queuing.
REQ-021 On entry to LOAD, the write pointer and the byte counter SHALL clear to 0 and load_full SHALL clear to 0.
REQ-022 In LOAD, each load_valid=1 SHALL shift load_byte into a 32-bit assembly register (big-endian: first byte lands in [31:24]).
REQ-023 The fourth byte SHALL write the assembled word to memory[pointer] in the same cycle, increment the pointer and zero the byte counter.
REQ-024 When the pointer reaches DEPTH, load_full SHALL rise; further bytes SHALL be ignored, with no wrap-around.
REQ-025 Leaving LOAD with a partial word (byte counter != 0) SHALL discard the partial word; memory SHALL be unchanged for that word.
REQ-026 When load_en rises in the same cycle as fetch_req in READY, LOAD SHALL win and the fetch SHALL be dropped.
REQ-027 A fetch of a word written in LOAD SHALL return the new value on the first READY request.
REQ-028 load_valid outside LOAD SHALL be ignored.

Reset
REQ-029 On reset low, the following SHALL clear: instruction=0, fetch_valid=0, fetch_err=0, load_full=0, pointer/counters=0, assembly register=0.
REQ-030 After reset release, the state SHALL be BOOT with busy=1 when IMEM_BOOT_CLEAR_EN is defined, otherwise READY.
REQ-031 Reset asserted mid-LOAD SHALL abort the load; words already written SHALL be retained unless BOOT clears them.

Configuration
REQ-032 IMEM_BOOT_CLEAR_EN defined SHALL make BOOT write 0 to one word per cycle, index 0..DEPTH-1, so BOOT lasts DEPTH cycles before READY.
REQ-033 IMEM_BOOT_CLEAR_EN undefined SHALL omit BOOT entirely; memory contents SHALL persist across reset (undefined at power-up).

Verification
REQ-034 Reset release with IMEM_BOOT_CLEAR_EN, DEPTH=64 -> busy=1 for 64 cycles; then fetch 0x0 -> instruction=0, fetch_valid=1, fetch_err=0.
REQ-035 load_en=1; bytes 20,08,00,20,20,09,00,37; load_en=0; fetch 0x0 then 0x4 on consecutive cycles -> 0x20080020 then 0x20090037 on consecutive cycles, no fetch_err.
REQ-036 Fetch 0x6 -> instruction=0, fetch_err=1; fetch 0x100 with DEPTH=64 -> instruction=0, fetch_err=1.
REQ-037 Load 258 bytes with DEPTH=64 -> load_full=1 after byte 256, bytes 257-258 ignored; word 63 = last full word written; word 0 = first word.
REQ-038 Load 6 bytes, then drop load_en -> word 0 written, word 1 unchanged (0).
REQ-039 Assert reset mid-LOAD -> all outputs 0 immediately; fetch_req during BOOT -> no fetch_valid.
